// File: rtl/vga_draw_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg: shared definitions for the VGA draw-port arbiter and the game
// controller.
//   - requester index constants (index 0 has the highest priority)
//   - per-engine colour table and screen bounds
//   - arbiter FSM state type
//   - helpers: colour lookup by engine index, on-screen test
// -----------------------------------------------------------------------------
package draw_pkg;

   localparam int unsigned NUM_ENGINES = 5;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned XY_W        = 15;

   localparam logic [IDX_W-1:0] REQ_CLEAR   = 3'd0;
   localparam logic [IDX_W-1:0] REQ_GALLOWS = 3'd1;
   localparam logic [IDX_W-1:0] REQ_DASH    = 3'd2;
   localparam logic [IDX_W-1:0] REQ_PARTS   = 3'd3;
   localparam logic [IDX_W-1:0] REQ_FILL    = 3'd4;

   localparam logic [7:0] SCREEN_W = 8'd160;
   localparam logic [6:0] SCREEN_H = 7'd120;

   localparam logic [2:0] COLOUR_TABLE [NUM_ENGINES] = '{
      3'b000,  // clear
      3'b001,  // gallows
      3'b111,  // dashes
      3'b100,  // parts
      3'b010   // fill
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAW    = 2'd1,
      ST_RELEASE = 2'd2
   } draw_state_e;

   function automatic logic [2:0] colour_of(input logic [IDX_W-1:0] idx);
      logic [2:0] c;
      case (idx)
         REQ_CLEAR:   c = COLOUR_TABLE[0];
         REQ_GALLOWS: c = COLOUR_TABLE[1];
         REQ_DASH:    c = COLOUR_TABLE[2];
         REQ_PARTS:   c = COLOUR_TABLE[3];
         REQ_FILL:    c = COLOUR_TABLE[4];
         default:     c = '0;
      endcase
      return c;
   endfunction

   function automatic logic on_screen(input logic [7:0] px, input logic [6:0] py);
      return (px < SCREEN_W) && (py < SCREEN_H);
   endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter_if: drawing-engine / VGA-side bundle of the draw arbiter.
//   master (engines + controller side):
//     out req[NREQ], done[NREQ], xy_in[NREQ*15] ({x[7:0],y[6:0]} per engine),
//         plot_in[NREQ]
//     in  grant[NREQ], x[8], y[7], colour[3], plot, busy, fin[NREQ],
//         err_timeout
//   slave (arbiter side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface vga_draw_arbiter_if #(
   parameter int unsigned NREQ = 5
);
   import draw_pkg::*;

   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      done;
   logic [NREQ*XY_W-1:0] xy_in;
   logic [NREQ-1:0]      plot_in;
   logic [NREQ-1:0]      grant;
   logic [7:0]           x;
   logic [6:0]           y;
   logic [2:0]           colour;
   logic                 plot;
   logic                 busy;
   logic [NREQ-1:0]      fin;
   logic                 err_timeout;

   modport master (
      output req, done, xy_in, plot_in,
      input  grant, x, y, colour, plot, busy, fin, err_timeout
   );

   modport slave (
      input  req, done, xy_in, plot_in,
      output grant, x, y, colour, plot, busy, fin, err_timeout
   );

endinterface

// File: rtl/vga_draw_arbiter_prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick: combinational lowest-index-wins selector.
//   i_req   in  NREQ   request vector
//   o_grant out NREQ   one-hot of the lowest set bit, or all zero
//   o_idx   out IDX_W  binary index of that bit (0 when nothing is set)
//   o_any   out 1      any request present
// -----------------------------------------------------------------------------
module prio_pick #(
   parameter int unsigned NREQ  = 5,
   parameter int unsigned IDX_W = 3
) (
   input  logic [NREQ-1:0]  i_req,
   output logic [NREQ-1:0]  o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Two's-complement trick isolates the lowest set bit.
   assign o_grant = i_req & (~i_req + NREQ'(1));
   assign o_any   = |i_req;

   always_comb begin
      o_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (o_grant[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter: shares the single VGA framebuffer write port among the
// drawing engines (clear, gallows, dashes, parts, fill). Fixed priority,
// non-preemptive: the granted engine owns the port until done, abort (req
// dropped) or watchdog timeout. The granted engine's pixel stream is
// registered onto x/y/plot with a per-engine colour; off-screen pixels are
// suppressed.
//   clk     in   system clock
//   resetn  in   asynchronous reset, active high
//   bus     slave modport of vga_draw_arbiter_if (req/done/xy_in/plot_in in,
//           grant/x/y/colour/plot/busy/fin/err_timeout out)
// TIMEOUT is the number of DRAW cycles per grant; must be 1..32767.
// -----------------------------------------------------------------------------
module vga_draw_arbiter
   import draw_pkg::*;
#(
   parameter int unsigned NREQ    = NUM_ENGINES,
   parameter int unsigned TIMEOUT = 19200
) (
   input logic               clk,
   input logic               resetn,
   vga_draw_arbiter_if.slave bus
);

   localparam logic [14:0] WD_LAST = 15'(TIMEOUT - 1);

   draw_state_e      r_state,  w_state_nxt;
   logic [NREQ-1:0]  r_grant,  w_grant_nxt;
   logic [IDX_W-1:0] r_idx,    w_idx_nxt;
   logic [14:0]      r_wdog,   w_wdog_nxt;
   logic [7:0]       r_x,      w_x_nxt;
   logic [6:0]       r_y,      w_y_nxt;
   logic [2:0]       r_colour, w_colour_nxt;
   logic             r_plot,   w_plot_nxt;
   logic [NREQ-1:0]  r_fin,    w_fin_nxt;
   logic             r_err,    w_err_nxt;

   logic [NREQ-1:0]  w_pick;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_any;

   logic [XY_W-1:0]  w_xy [NREQ];
   logic [XY_W-1:0]  w_xy_k;
   logic             w_req_k;
   logic             w_done_k;
   logic             w_plot_k;
   logic             w_on_screen;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign w_xy[gi] = bus.xy_in[gi*XY_W +: XY_W];
      end
   endgenerate

   // Signals of the currently granted engine only; others are don't-care.
   assign w_xy_k      = w_xy[r_idx];
   assign w_req_k     = bus.req[r_idx];
   assign w_done_k    = bus.done[r_idx];
   assign w_plot_k    = bus.plot_in[r_idx];
   assign w_on_screen = on_screen(w_xy_k[14:7], w_xy_k[6:0]);

   prio_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (bus.req),
      .o_grant (w_pick),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_idx_nxt    = r_idx;
      w_wdog_nxt   = r_wdog;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_colour_nxt = r_colour;
      w_plot_nxt   = 1'b0;
      w_fin_nxt    = '0;
      w_err_nxt    = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = ST_DRAW;
               w_grant_nxt = w_pick;
               w_idx_nxt   = w_pick_idx;
               w_wdog_nxt  = '0;
            end
         end

         ST_DRAW: begin
            w_x_nxt      = w_xy_k[14:7];
            w_y_nxt      = w_xy_k[6:0];
            w_colour_nxt = colour_of(r_idx);
            w_plot_nxt   = w_plot_k && w_on_screen;
            w_wdog_nxt   = (r_wdog == WD_LAST) ? r_wdog : r_wdog + 15'd1;

            // Exit precedence: done, then abort, then watchdog.
            if (w_done_k) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
               w_fin_nxt   = r_grant;
            end else if (!w_req_k) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
               w_plot_nxt  = 1'b0;
            end else if (r_wdog == WD_LAST) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
               w_err_nxt   = 1'b1;
            end
         end

         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_idx    <= '0;
         r_wdog   <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
         r_fin    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_idx    <= w_idx_nxt;
         r_wdog   <= w_wdog_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_colour <= w_colour_nxt;
         r_plot   <= w_plot_nxt;
         r_fin    <= w_fin_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.x           = r_x;
   assign bus.y           = r_y;
   assign bus.colour      = r_colour;
   assign bus.plot        = r_plot;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.fin         = r_fin;
   assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vga_draw_arbiter. Engines are played by tasks that
// present pixels to the granted engine and random garbage on all others;
// expected grant order, pixel outputs and completion pulses come from the
// arbitration rules (lowest pending index wins, one grant per job, two idle
// cycles between grants).
// -----------------------------------------------------------------------------
module tb_vga_draw_arbiter;

   localparam int NREQ = 5;
   localparam int TO   = 8;
   localparam logic [2:0] COL [NREQ] = '{3'b000, 3'b001, 3'b111, 3'b100, 3'b010};

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   vga_draw_arbiter_if #(.NREQ(NREQ)) bus ();

   vga_draw_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TO)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [NREQ-1:0] pend = '0;
   logic [7:0] fx[$];
   logic [6:0] fy[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int k);
      logic [NREQ-1:0] r;
      r = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   function automatic int lowest(input logic [NREQ-1:0] p);
      for (int i = 0; i < NREQ; i++) if (p[i]) return i;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] winner(input logic [NREQ-1:0] p);
      return (p == '0) ? '0 : oh(lowest(p));
   endfunction

   // Granted engine k (k<0: none) gets the given pixel; the rest is random.
   task automatic drive(input int k, input logic [7:0] px, input logic [6:0] py,
                        input logic pp, input logic dd);
      logic [NREQ*15-1:0] xy;
      logic [NREQ-1:0]    pl, dn;
      for (int i = 0; i < NREQ; i++) xy[15*i +: 15] = 15'($urandom);
      pl = NREQ'($urandom);
      dn = NREQ'($urandom);
      if (k >= 0) begin
         xy[15*k +: 15] = {px, py};
         pl[k] = pp;
         dn[k] = dd;
      end
      bus.req     = pend;
      bus.xy_in   = xy;
      bus.plot_in = pl;
      bus.done    = dn;
   endtask

   // From idle: raise requests and expect the winner one cycle later.
   task automatic start(input logic [NREQ-1:0] bits);
      pend |= bits;
      drive(-1, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("grant_start", bus.grant, winner(pend));
      chk("busy_start", bus.busy, 1'b1);
   endtask

   // mode: 0 done, 1 abort (req drop), 2 timeout, 3 done with req drop.
   task automatic serve(input int k, input int npix, input int mode,
                        input logic [NREQ-1:0] raise_mid);
      logic [7:0] px;
      logic [6:0] py;
      logic pp, dd, ep, last;
      for (int c = 0; c < npix; c++) begin
         last = (c == npix - 1);
         if (fx.size() > 0) begin
            px = fx.pop_front();
            py = fy.pop_front();
            pp = 1'b1;
         end else begin
            px = 8'($urandom_range(0, 175));
            py = 7'($urandom_range(0, 127));
            pp = ($urandom_range(0, 3) != 0);
         end
         dd = last && (mode == 0 || mode == 3);
         if (c == 0) pend |= raise_mid & ~oh(k);
         if (last && (mode == 1 || mode == 3)) pend[k] = 1'b0;
         drive(k, px, py, pp, dd);
         @(negedge clk);
         ep = pp && (px < 8'd160) && (py < 7'd120) && !(last && mode == 1);
         chk("plot", bus.plot, ep);
         if (ep) begin
            chk("x", bus.x, px);
            chk("y", bus.y, py);
            chk("colour", bus.colour, COL[k]);
         end
         chk("busy_draw", bus.busy, 1'b1);
         if (!last) begin
            chk("grant_hold", bus.grant, oh(k));
            chk("fin_draw", bus.fin, '0);
            chk("err_draw", bus.err_timeout, 1'b0);
         end else begin
            chk("grant_release", bus.grant, '0);
            chk("fin_release", bus.fin, (mode == 0 || mode == 3) ? oh(k) : '0);
            chk("err_release", bus.err_timeout, mode == 2);
         end
      end
      pend[k] = 1'b0;
      drive(-1, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("busy_idle", bus.busy, 1'b0);
      chk("grant_idle", bus.grant, '0);
      chk("plot_idle", bus.plot, 1'b0);
      chk("fin_idle", bus.fin, '0);
      chk("err_idle", bus.err_timeout, 1'b0);
      drive(-1, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("grant_next", bus.grant, winner(pend));
      chk("busy_next", bus.busy, pend != '0);
   endtask

   initial begin
      int k, mode, npix;
      resetn = 1'b1;
      drive(-1, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_grant", bus.grant, '0);
      chk("rst_plot", bus.plot, 1'b0);
      chk("rst_x", bus.x, '0);
      chk("rst_y", bus.y, '0);
      chk("rst_colour", bus.colour, '0);
      chk("rst_fin", bus.fin, '0);
      chk("rst_err", bus.err_timeout, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      resetn = 1'b0;
      @(negedge clk);
      chk("idle_grant", bus.grant, '0);

      // Single request, three pixels, done on the third.
      fx = '{8'd100, 8'd101, 8'd102};
      fy = '{7'd20, 7'd20, 7'd20};
      start(5'b00010);
      serve(1, 3, 0, '0);

      // Priority: clear wins, then dashes, parts, fill.
      start(5'b11101);
      while (pend != '0) serve(lowest(pend), $urandom_range(1, TO), 0, '0);

      // No preemption: clear raised while parts is drawing.
      start(5'b01000);
      serve(3, 5, 0, 5'b00001);
      serve(0, 2, 0, '0);

      // Clipping.
      fx = '{8'd160, 8'd159};
      fy = '{7'd10, 7'd119};
      start(5'b00100);
      serve(2, 2, 0, '0);

      // Abort, timeout, done together with req drop.
      start(5'b10000);
      serve(4, 4, 1, '0);
      start(5'b00010);
      serve(1, TO, 2, '0);
      start(5'b00001);
      serve(0, TO, 3, '0);

      // Asynchronous reset mid-DRAW; the request stays pending.
      start(5'b01000);
      drive(3, 8'd10, 7'd10, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_rst_plot", bus.plot, 1'b1);
      drive(3, 8'd11, 7'd10, 1'b1, 1'b0);
      @(posedge clk);
      #2 resetn = 1'b1;
      #1;
      chk("arst_grant", bus.grant, '0);
      chk("arst_plot", bus.plot, 1'b0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_fin", bus.fin, '0);
      @(negedge clk);
      resetn = 1'b0;
      drive(-1, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("regrant", bus.grant, 5'b01000);
      serve(3, 3, 0, '0);

      // Randomized jobs.
      for (int it = 0; it < 40; it++) begin
         if (pend == '0) start(NREQ'($urandom_range(1, 31)));
         k    = lowest(pend);
         mode = $urandom_range(0, 3);
         npix = (mode == 2) ? TO : $urandom_range(1, TO);
         serve(k, npix, mode, NREQ'($urandom) & NREQ'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
